// File: rtl/nbit_miso_spi_buffer.sv
// nbit_miso_spi_buffer: deserialises MISO bits sampled on rising i_SCK into
// WIDTH-bit bytes and packs up to N bytes per frame into a wide parallel word.
// Ports: i_SCK/i_RST_N (clock, async active-low reset), i_MISO (serial in),
//   i_START/i_N_receive (frame request and byte count; 0 or >N means N),
//   o_DATA (packed frame, byte k at [k*WIDTH +: WIDTH]), o_BYTE/o_BYTE_IDX
//   (last completed byte and its index), o_BYTE_VALID/o_DONE (1-cycle strobes),
//   o_BUSY (high while receiving).
// Latency: a k-byte frame raises o_DONE k*WIDTH edges after the start edge.
// Build option: define MISO_LSB_FIRST_EN for LSB-first bit order (default MSB-first).
module nbit_miso_spi_buffer #(
  parameter int WIDTH = 8,
  parameter int N     = 8
) (
  input  logic               i_SCK,
  input  logic               i_RST_N,
  input  logic               i_MISO,
  input  logic               i_START,
  input  logic [4:0]         i_N_receive,
  output logic [WIDTH*N-1:0] o_DATA,
  output logic [WIDTH-1:0]   o_BYTE,
  output logic [4:0]         o_BYTE_IDX,
  output logic               o_BYTE_VALID,
  output logic               o_DONE,
  output logic               o_BUSY
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_RECEIVE = 1'b1;

  localparam int             BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]  LAST_BIT = BW'(WIDTH - 1);
  localparam logic [4:0]     N_MAX    = 5'(N);

  logic [0:0]       state;
  logic [4:0]       count;
  logic [4:0]       byte_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] assembled;
  logic [4:0]       n_clamped;

  // Value of the shift register including the bit sampled on this edge; on
  // the last bit of a byte this is the complete byte.
  always_comb begin
`ifdef MISO_LSB_FIRST_EN
    assembled = {i_MISO, shift_reg[WIDTH-1:1]};
`else
    assembled = {shift_reg[WIDTH-2:0], i_MISO};
`endif
  end

  always_comb begin
    n_clamped = i_N_receive;
    if (i_N_receive == 5'd0 || i_N_receive > N_MAX) begin
      n_clamped = N_MAX;
    end
  end

  assign o_BUSY = (state == S_RECEIVE);

  always_ff @(posedge i_SCK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state        <= S_IDLE;
      count        <= '0;
      byte_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      o_DATA       <= '0;
      o_BYTE       <= '0;
      o_BYTE_IDX   <= '0;
      o_BYTE_VALID <= 1'b0;
      o_DONE       <= 1'b0;
    end else begin
      o_BYTE_VALID <= 1'b0;
      o_DONE       <= 1'b0;
      case (state)
        S_IDLE: begin
          // The start edge only arms the receiver; bit 0 comes on the next edge.
          if (i_START) begin
            state     <= S_RECEIVE;
            count     <= n_clamped;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end
        default: begin
          shift_reg <= assembled;
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt      <= '0;
            byte_cnt     <= byte_cnt + 1'b1;
            o_BYTE       <= assembled;
            o_BYTE_IDX   <= byte_cnt;
            o_BYTE_VALID <= 1'b1;
            for (int k = 0; k < N; k++) begin
              if (byte_cnt == 5'(k)) begin
                o_DATA[k*WIDTH +: WIDTH] <= assembled;
              end
            end
            if (byte_cnt == count - 5'd1) begin
              o_DONE <= 1'b1;
              // i_START on the final edge chains the next frame with no gap.
              if (i_START) begin
                count    <= n_clamped;
                byte_cnt <= '0;
              end else begin
                state <= S_IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
